// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared constants for the sequential MAC: default widths,
//               FSM state encoding and iteration-counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam int c_DEF_WIDTH = 6;
    localparam int c_DEF_ACC_W = 16;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_ACC  = 2'd2;
    localparam logic [1:0] c_ST_HOLD = 2'd3;

    // Counter must be able to represent 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_sat_add.sv
`default_nettype none
// ============================================================================
// Module      : mac_sat_add
// Description : Combinational unsigned adder that saturates to all ones on
//               carry-out and reports the overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_sat_add #(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] addend,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W:0] w_raw;

    assign w_raw = {1'b0, acc} + {1'b0, addend};
    assign ovf   = w_raw[ACC_W];
    assign sum   = w_raw[ACC_W] ? {ACC_W{1'b1}} : w_raw[ACC_W-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_mac_core.sv
`default_nettype none
// ============================================================================
// Module      : seq_mac_core
// Description : Shift-add multiplier feeding a saturating accumulator, with a
//               valid/ready handshake on both operand and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mac_core
    import mac_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int ACC_W = c_DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf
);

    localparam int c_CNT_W = cnt_width(WIDTH);
    localparam int c_PW    = 2 * WIDTH;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    if (ACC_W < 2 * WIDTH) begin : g_acc_w_check
        $error("seq_mac_core: ACC_W must be at least 2*WIDTH");
    end

    logic [1:0]         r_state;
    logic [c_PW-1:0]    r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_PW-1:0]    r_prod;
    logic [c_CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [ACC_W-1:0]   w_sum;
    logic               w_carry;

    mac_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc    (r_acc),
        .addend (ACC_W'(r_prod)),
        .sum    (w_sum),
        .ovf    (w_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // Clear first so a same-cycle accept accumulates onto zero.
                    if (acc_clr) begin
                        r_acc <= '0;
                        r_ovf <= 1'b0;
                    end
                    if (in_valid) begin
                        r_mcand    <= c_PW'(a);
                        r_mplier   <= b;
                        r_prod     <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= c_ST_MUL;
                    end
                end
                c_ST_MUL: begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_state <= c_ST_ACC;
                    end
                end
                c_ST_ACC: begin
                    r_acc       <= w_sum;
                    r_ovf       <= r_ovf | w_carry;
                    r_out_valid <= 1'b1;
                    r_state     <= c_ST_HOLD;
                end
                c_ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign acc_out   = r_acc;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
